result_presenter: RTL and testbench

RESULT_PRESENTER -- requirements
Module: result_presenter

---
 rtl/presenter_pkg.sv | 11 +
 rtl/dwell_timer.sv | 33 +++
 rtl/result_presenter.sv | 97 +++++++++
 tb/tb_result_presenter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/presenter_pkg.sv
// Shared types and helpers for the result presenter.
package presenter_pkg;

  typedef enum logic {FILL, SHOW} presenter_state_e;

  // Bit width able to index v items, never narrower than one bit.
  function automatic int safe_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter; tick_o marks the last cycle of each dwell period.
module dwell_timer
  import presenter_pkg::*;
#(
  parameter int dwell_p = 60_000_000
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int tw = safe_clog2(dwell_p);
  localparam logic [tw-1:0] last_count = tw'(dwell_p - 1);

  logic [tw-1:0] count;

  assign tick_o = en_i && (count == last_count);

  // clear wins over counting so an advance restarts the dwell at zero
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (en_i) begin
      if (tick_o) count <= '0;
      else        count <= count + tw'(1);
    end
  end

endmodule

// File: rtl/result_presenter.sv
// Collects depth_p results, then shows each one for dwell_p cycles before
// returning to collection.
module result_presenter
  import presenter_pkg::*;
#(
  parameter int width_p = 8,
  parameter int depth_p = 4,
  parameter int dwell_p = 60_000_000
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           valid_i,
  input  logic [width_p-1:0]             data_i,
  output logic                           ready_o,
  input  logic                           flush_i,
  input  logic                           advance_i,
  output logic [width_p-1:0]             data_o,
  output logic [safe_clog2(depth_p)-1:0] index_o,
  output logic                           show_o,
  output logic                           done_o
);

  localparam int iw = safe_clog2(depth_p);
  localparam int cw = safe_clog2(depth_p + 1);
  localparam logic [iw-1:0] last_index = iw'(depth_p - 1);
  localparam logic [cw-1:0] last_slot  = cw'(depth_p - 1);

  presenter_state_e state, next_state;
  logic [cw-1:0]      count;
  logic [iw-1:0]      index;
  logic [width_p-1:0] buffer [depth_p];
  logic               xfer;
  logic               step;
  logic               tick;
  logic               timer_clear;

  dwell_timer #(.dwell_p(dwell_p)) u_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (timer_clear),
    .en_i      (show_o),
    .tick_o    (tick)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= FILL;
    else            state <= next_state;
  end

  // An advance pulse and a timer tick in the same cycle merge into one step.
  always_comb begin
    next_state  = state;
    ready_o     = 1'b0;
    show_o      = 1'b0;
    step        = 1'b0;
    done_o      = 1'b0;
    timer_clear = 1'b1;
    xfer        = 1'b0;
    unique case (state)
      FILL: begin
        ready_o = 1'b1;
        xfer    = valid_i && !flush_i;
        if (xfer && count == last_slot) next_state = SHOW;
      end
      SHOW: begin
        show_o      = 1'b1;
        step        = !flush_i && (advance_i || tick);
        done_o      = step && (index == last_index);
        timer_clear = flush_i || advance_i;
        if (done_o) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
    if (flush_i) next_state = FILL;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
      index <= '0;
    end else if (flush_i || done_o) begin
      count <= '0;
      index <= '0;
    end else begin
      if (xfer) count <= count + cw'(1);
      if (step) index <= index + iw'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (xfer) buffer[count[iw-1:0]] <= data_i;
  end

  assign data_o  = show_o ? buffer[index] : '0;
  assign index_o = show_o ? index : '0;

endmodule

// File: tb/tb_result_presenter.sv
// Directed self-checking bench for result_presenter with depth 4, dwell 3.
module tb_result_presenter;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       flush_i;
  logic       advance_i;
  logic [7:0] data_o;
  logic [1:0] index_o;
  logic       show_o;
  logic       done_o;

  int checks   = 0;
  int failures = 0;
  int done_seen;
  logic [7:0] first_set [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  result_presenter #(.width_p(8), .depth_p(4), .dwell_p(3)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .advance_i (advance_i),
    .data_o    (data_o),
    .index_o   (index_o),
    .show_o    (show_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer: inputs change on the falling edge, capture on the next rising edge.
  task automatic applyStimulus(input logic [7:0] d);
    valid_i = 1'b1;
    data_i  = d;
    @(negedge clk_i);
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  initial begin
    reset_n_i = 1'b0;
    valid_i   = 1'b0;
    data_i    = 8'h00;
    flush_i   = 1'b0;
    advance_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_ready", ready_o, 1);
    checkOutput("reset_show", show_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_data", data_o, 0);
    checkOutput("reset_index", index_o, 0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    $display("[TB] back-to-back fill and full display");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fill_ready_%0d", i), ready_o, 1);
      valid_i = 1'b1;
      data_i  = first_set[i];
      @(negedge clk_i);
    end
    checkOutput("fill_ready_drop", ready_o, 0);
    checkOutput("fill_show_on", show_o, 1);
    data_i    = 8'hFF;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("show_data_%0d", k), data_o, first_set[k/3]);
      checkOutput($sformatf("show_index_%0d", k), index_o, k / 3);
      checkOutput($sformatf("show_done_%0d", k), done_o, (k == 11) ? 1 : 0);
      if (done_o) done_seen++;
      if (k == 11) valid_i = 1'b0;
      @(negedge clk_i);
    end
    checkOutput("done_once", done_seen, 1);
    checkOutput("refill_ready", ready_o, 1);
    checkOutput("refill_show", show_o, 0);
    checkOutput("refill_data", data_o, 0);

    advance_i = 1'b1;
    @(negedge clk_i);
    advance_i = 1'b0;
    checkOutput("fill_adv_show", show_o, 0);
    checkOutput("fill_adv_ready", ready_o, 1);

    $display("[TB] advance pulse and coincident terminal");
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    applyStimulus(8'hA4);
    checkOutput("adv_show_on", show_o, 1);
    checkOutput("adv_first", data_o, 8'hA1);
    @(negedge clk_i);
    advance_i = 1'b1;
    @(negedge clk_i);
    advance_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("adv_hold_index_%0d", k), index_o, 1);
      checkOutput($sformatf("adv_hold_data_%0d", k), data_o, 8'hA2);
      if (k < 2) @(negedge clk_i);
    end
    advance_i = 1'b1;
    @(negedge clk_i);
    advance_i = 1'b0;
    checkOutput("coinc_index", index_o, 2);
    checkOutput("coinc_data", data_o, 8'hA3);
    repeat (3) @(negedge clk_i);
    checkOutput("last_index", index_o, 3);
    repeat (2) @(negedge clk_i);
    checkOutput("flush_term_index", index_o, 3);
    flush_i = 1'b1;
    #1;
    checkOutput("flush_term_done", done_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flush_term_show", show_o, 0);
    checkOutput("flush_term_ready", ready_o, 1);
    checkOutput("flush_term_idx0", index_o, 0);

    $display("[TB] flush mid-fill");
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    applyStimulus(8'h51);
    applyStimulus(8'h52);
    applyStimulus(8'h53);
    checkOutput("flush_three_show", show_o, 0);
    checkOutput("flush_three_ready", ready_o, 1);
    applyStimulus(8'h54);
    checkOutput("flush_four_show", show_o, 1);
    checkOutput("flush_four_data", data_o, 8'h51);

    $display("[TB] asynchronous reset mid-display");
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    checkOutput("async_rst_show", show_o, 0);
    checkOutput("async_rst_ready", ready_o, 1);
    checkOutput("async_rst_done", done_o, 0);
    checkOutput("async_rst_data", data_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("post_rst_show", show_o, 0);
    checkOutput("post_rst_index", index_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
